// File: rtl/axi_read_sched_pkg.sv
// Shared types and constants for the AXI3 read scheduler: requester indices,
// FSM state encoding and the cache-line compare used for write hazards.
package axi_read_sched_pkg;

    localparam int DEF_NREQ             = 3;
    localparam int DEF_LINE_BYTE_OFFSET = 6;
    localparam int DEF_AXI_ID_W         = 4;

    localparam int REQ_ICACHE   = 0;
    localparam int REQ_DCACHE   = 1;
    localparam int REQ_UNCACHED = 2;

    localparam logic [1:0] AXI_BURST_INCR = 2'b01;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_DATA = 2'd2
    } state_t;

    // True when both addresses fall in the same cache line.
    function automatic logic same_line(input logic [31:0] a,
                                       input logic [31:0] b,
                                       input int          lbo);
        return (a >> lbo) == (b >> lbo);
    endfunction

endpackage

// File: rtl/axi_read_sched_if.sv
// AXI3 read address / read data channel bundle. The master modport is the
// scheduler side, the slave modport is the interconnect side.
interface axi_read_sched_if
    import axi_read_sched_pkg::*;
#(
    parameter int ID_W = DEF_AXI_ID_W
);
    logic [ID_W-1:0] arid;
    logic [31:0]     araddr;
    logic [3:0]      arlen;
    logic [2:0]      arsize;
    logic [1:0]      arburst;
    logic [1:0]      arlock;
    logic [3:0]      arcache;
    logic [2:0]      arprot;
    logic            arvalid;
    logic            arready;

    logic [ID_W-1:0] rid;
    logic [31:0]     rdata;
    logic [1:0]      rresp;
    logic            rlast;
    logic            rvalid;
    logic            rready;

    modport master (
        output arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot,
        output arvalid, rready,
        input  arready, rid, rdata, rresp, rlast, rvalid
    );

    modport slave (
        input  arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot,
        input  arvalid, rready,
        output arready, rid, rdata, rresp, rlast, rvalid
    );

endinterface

// File: rtl/axi_read_sched_rr_arbiter.sv
// Combinational round-robin pick: first eligible index at or above the
// pointer, wrapping around to index 0.
module rr_arbiter #(
    parameter int NREQ  = 3,
    parameter int IDX_W = 2
) (
    input  logic [NREQ-1:0]  i_elig,
    input  logic [IDX_W-1:0] i_ptr,
    output logic             o_valid,
    output logic [IDX_W-1:0] o_idx
);

    always_comb begin
        int w_cand;
        o_valid = 1'b0;
        o_idx   = '0;
        w_cand  = 0;
        // Walk from the farthest offset down so the nearest eligible index wins.
        for (int k = NREQ - 1; k >= 0; k--) begin
            w_cand = (int'(i_ptr) + k) % NREQ;
            if (i_elig[w_cand[IDX_W-1:0]]) begin
                o_valid = 1'b1;
                o_idx   = w_cand[IDX_W-1:0];
            end
        end
    end

endmodule

// File: rtl/axi_read_sched.sv
// Round-robin scheduler of cache line-fill and uncached reads onto a single
// AXI3 read channel, one transaction in flight, with write-hazard hold-off.
module axi_read_sched
    import axi_read_sched_pkg::*;
#(
    parameter int NREQ             = DEF_NREQ,
    parameter int LINE_BYTE_OFFSET = DEF_LINE_BYTE_OFFSET,
    parameter int AXI_ID_W         = DEF_AXI_ID_W
) (
    input  logic                i_clk,
    input  logic                i_rst_n,

    input  logic [NREQ-1:0]     i_req_valid,
    input  logic [NREQ*32-1:0]  i_req_addr,
    input  logic [NREQ*4-1:0]   i_req_len,
    input  logic [NREQ*3-1:0]   i_req_size,
    output logic [NREQ-1:0]     o_req_ready,

    output logic [NREQ-1:0]     o_resp_valid,
    output logic [31:0]         o_resp_data,
    output logic                o_resp_last,
    output logic                o_resp_err,

    input  logic                i_write_process,
    input  logic [31:0]         i_write_address,

    output logic                o_idle,
    output state_t              o_dbg_state,

    axi_read_sched_if.master    m_axi
);

    localparam int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [IDX_W-1:0] r_rr_ptr;
    logic [IDX_W-1:0] r_grant;
    logic [31:0]      r_araddr;
    logic [3:0]       r_arlen;
    logic [2:0]       r_arsize;

    logic [NREQ-1:0]  w_elig;
    logic             w_pick_valid;
    logic [IDX_W-1:0] w_pick_idx;
    logic             w_unused_rid;

    // Hazard is evaluated only here, at arbitration; a granted request is never recalled.
    always_comb begin
        w_elig = '0;
        for (int k = 0; k < NREQ; k++) begin
            w_elig[k] = i_req_valid[k] &&
                        !(i_write_process &&
                          same_line(i_req_addr[k*32 +: 32], i_write_address, LINE_BYTE_OFFSET));
        end
    end

    rr_arbiter #(
        .NREQ  (NREQ),
        .IDX_W (IDX_W)
    ) u_rr_arbiter (
        .i_elig  (w_elig),
        .i_ptr   (r_rr_ptr),
        .o_valid (w_pick_valid),
        .o_idx   (w_pick_idx)
    );

    always_comb begin
        w_state_nxt    = r_state;
        o_req_ready    = '0;
        o_resp_valid   = '0;
        o_resp_last    = 1'b0;
        o_resp_err     = 1'b0;
        m_axi.arvalid  = 1'b0;
        m_axi.rready   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_pick_valid) w_state_nxt = ST_ADDR;
            end
            ST_ADDR: begin
                m_axi.arvalid = 1'b1;
                if (m_axi.arready) begin
                    o_req_ready[r_grant] = 1'b1;
                    w_state_nxt          = ST_DATA;
                end
            end
            ST_DATA: begin
                m_axi.rready = 1'b1;
                // rid is ignored: only one burst can be outstanding.
                if (m_axi.rvalid) begin
                    o_resp_valid[r_grant] = 1'b1;
                    o_resp_last           = m_axi.rlast;
                    o_resp_err            = (m_axi.rresp != 2'b00);
                    if (m_axi.rlast) w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state  <= ST_IDLE;
            r_rr_ptr <= '0;
            r_grant  <= '0;
            r_araddr <= '0;
            r_arlen  <= '0;
            r_arsize <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (r_state == ST_IDLE && w_pick_valid) begin
                r_grant  <= w_pick_idx;
                r_araddr <= i_req_addr[int'(w_pick_idx)*32 +: 32];
                r_arlen  <= i_req_len[int'(w_pick_idx)*4 +: 4];
                r_arsize <= i_req_size[int'(w_pick_idx)*3 +: 3];
            end
            if (r_state == ST_ADDR && m_axi.arready) begin
                r_rr_ptr <= (r_grant == IDX_W'(NREQ - 1)) ? '0 : r_grant + 1'b1;
            end
        end
    end

    assign m_axi.arid    = AXI_ID_W'(r_grant);
    assign m_axi.araddr  = r_araddr;
    assign m_axi.arlen   = r_arlen;
    assign m_axi.arsize  = r_arsize;
    assign m_axi.arburst = AXI_BURST_INCR;
    assign m_axi.arlock  = 2'b00;
    assign m_axi.arcache = 4'b0000;
    assign m_axi.arprot  = 3'b000;

    assign o_resp_data  = m_axi.rdata;
    assign o_idle       = (r_state == ST_IDLE) && !(|i_req_valid);
    assign o_dbg_state  = r_state;
    assign w_unused_rid = ^m_axi.rid;

endmodule

// File: tb/tb_axi_read_sched.sv
// Bench for axi_read_sched: bus-functional AXI read slave, requester drivers,
// a round-robin/hazard reference model and a beat scoreboard.
module tb_axi_read_sched;
    import axi_read_sched_pkg::*;

    localparam int NREQ = 3;
    localparam int LBO  = 6;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic [NREQ-1:0]    req_valid;
    logic [NREQ*32-1:0] req_addr;
    logic [NREQ*4-1:0]  req_len;
    logic [NREQ*3-1:0]  req_size;
    logic [NREQ-1:0]    req_ready;
    logic [NREQ-1:0]    resp_valid;
    logic [31:0]        resp_data;
    logic               resp_last;
    logic               resp_err;
    logic               write_process;
    logic [31:0]        write_address;
    logic               idle;
    state_t             dbg_state;

    axi_read_sched_if bus ();

    axi_read_sched dut (
        .i_clk           (clk),
        .i_rst_n         (rst_n),
        .i_req_valid     (req_valid),
        .i_req_addr      (req_addr),
        .i_req_len       (req_len),
        .i_req_size      (req_size),
        .o_req_ready     (req_ready),
        .o_resp_valid    (resp_valid),
        .o_resp_data     (resp_data),
        .o_resp_last     (resp_last),
        .o_resp_err      (resp_err),
        .i_write_process (write_process),
        .i_write_address (write_address),
        .o_idle          (idle),
        .o_dbg_state     (dbg_state),
        .m_axi           (bus)
    );

    // Clock / global watchdog
    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation still running at %0t, required finish", $time);
        $fatal(1, "watchdog expired");
    end

    int          n_tests = 0;
    int          n_fail  = 0;
    int          model_ptr = 0;
    logic [31:0] exp_q[$];

    // Reference model: first valid, non-hazarded requester going upward from the pointer.
    function automatic int model_pick();
        for (int d = 0; d < NREQ; d++) begin
            int k;
            k = (model_ptr + d) % NREQ;
            if (req_valid[k] &&
                !(write_process && ((req_addr[k*32 +: 32] >> LBO) == (write_address >> LBO))))
                return k;
        end
        return -1;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        repeat (2) tick();
        rst_n = 1'b1;
        model_ptr = 0;
    endtask

    task automatic set_req(input int k, input logic [31:0] a, input logic [3:0] l,
                           input logic [2:0] s);
        req_addr[k*32 +: 32] = a;
        req_len[k*4 +: 4]    = l;
        req_size[k*3 +: 3]   = s;
        req_valid[k]         = 1'b1;
    endtask

    // Slave driver: AR handshake after ar_wait stall cycles, then the R burst.
    // abort_after >= 0 stops after that many beats (used for reset-in-burst).
    task automatic serve(input int exp_idx, input int ar_wait, input int max_gap,
                         input logic [1:0] rr, input bit seq_data, input int abort_after,
                         output int wait_cyc);
        int              t;
        int              nb;
        int              gap;
        int              le;
        int              got_id;
        logic [31:0]     a;
        logic [3:0]      l;
        logic [31:0]     e;
        logic [NREQ-1:0] oh;
        t = 0;
        while (!bus.arvalid && t < 64) begin
            tick();
            t++;
        end
        wait_cyc = t;
        n_tests++;
        if (!bus.arvalid) begin
            n_fail++;
            $display("FAIL ar_timeout: arvalid=0 after %0d cycles, required 1", t);
            return;
        end
        if (exp_idx < 0) begin
            n_fail++;
            $display("FAIL ar_unexpected: arvalid=1 arid=%0d, required no request", bus.arid);
            return;
        end
        oh = NREQ'(1) << exp_idx;
        le = int'(req_len[exp_idx*4 +: 4]);
        a  = bus.araddr;
        l  = bus.arlen;
        got_id = int'(bus.arid);
        n_tests++;
        if (bus.arid !== 4'(exp_idx)) begin
            n_fail++;
            $display("FAIL arid: got %0d, required %0d", bus.arid, exp_idx);
        end
        n_tests++;
        if (a !== req_addr[exp_idx*32 +: 32] || l !== req_len[exp_idx*4 +: 4] ||
            bus.arsize !== req_size[exp_idx*3 +: 3] || bus.arburst !== 2'b01) begin
            n_fail++;
            $display("FAIL ar_fields: got addr=%h len=%0d size=%0d burst=%0d, required addr=%h len=%0d size=%0d burst=1",
                     a, l, bus.arsize, bus.arburst, req_addr[exp_idx*32 +: 32],
                     req_len[exp_idx*4 +: 4], req_size[exp_idx*3 +: 3]);
        end
        repeat (ar_wait) begin
            @(negedge clk);
            n_tests++;
            if (bus.arvalid !== 1'b1 || bus.araddr !== a || bus.arlen !== l || req_ready !== '0) begin
                n_fail++;
                $display("FAIL ar_hold: got arvalid=%b addr=%h len=%0d req_ready=%b, required 1 %h %0d 000",
                         bus.arvalid, bus.araddr, bus.arlen, req_ready, a, l);
            end
            tick();
        end
        bus.arready = 1'b1;
        @(negedge clk);
        n_tests++;
        if (req_ready !== oh) begin
            n_fail++;
            $display("FAIL req_ready: got %b, required %b", req_ready, oh);
        end
        tick();
        bus.arready = 1'b0;
        if (got_id < NREQ) req_valid[got_id] = 1'b0;
        model_ptr = (exp_idx + 1) % NREQ;
        nb = (abort_after >= 0) ? abort_after : le + 1;
        for (int b = 0; b < nb; b++) begin
            gap = $urandom_range(max_gap, 0);
            repeat (gap) begin
                @(negedge clk);
                n_tests++;
                if (resp_valid !== '0) begin
                    n_fail++;
                    $display("FAIL resp_gap: got resp_valid=%b, required 000", resp_valid);
                end
                tick();
            end
            bus.rdata  = seq_data ? 32'(b) : $urandom();
            bus.rlast  = (b == le);
            bus.rresp  = rr;
            bus.rvalid = 1'b1;
            exp_q.push_back(bus.rdata);
            @(negedge clk);
            e = exp_q.pop_front();
            n_tests++;
            if (resp_valid !== oh || resp_data !== e || resp_last !== (b == le) ||
                resp_err !== (rr != 2'b00) || req_ready !== '0) begin
                n_fail++;
                $display("FAIL beat%0d: got v=%b d=%h last=%b err=%b rdy=%b, required v=%b d=%h last=%b err=%b rdy=000",
                         b, resp_valid, resp_data, resp_last, resp_err, req_ready,
                         oh, e, (b == le), (rr != 2'b00));
            end
            if (b == nb - 1 && abort_after >= 0) break;
            tick();
            bus.rvalid = 1'b0;
            bus.rlast  = 1'b0;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_tests++;
        if (idle !== 1'b1 || dbg_state !== ST_IDLE || bus.arvalid !== 1'b0 || bus.rready !== 1'b0 ||
            req_ready !== '0 || resp_valid !== '0 || resp_last !== 1'b0 || resp_err !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_ctrl: got idle=%b st=%0d arv=%b rr=%b rdy=%b rv=%b rl=%b re=%b, required 1 0 0 0 000 000 0 0",
                     idle, dbg_state, bus.arvalid, bus.rready, req_ready, resp_valid, resp_last, resp_err);
        end
        n_tests++;
        if (bus.araddr !== 32'h0 || bus.arlen !== 4'h0 || bus.arsize !== 3'h0 || bus.arid !== 4'h0 ||
            bus.arlock !== 2'b00 || bus.arcache !== 4'h0 || bus.arprot !== 3'h0) begin
            n_fail++;
            $display("FAIL reset_ar: got addr=%h len=%0d size=%0d id=%0d lock=%0d cache=%0d prot=%0d, required all 0",
                     bus.araddr, bus.arlen, bus.arsize, bus.arid, bus.arlock, bus.arcache, bus.arprot);
        end
        tick();
        rst_n = 1'b1;
        model_ptr = 0;
        tick();
    endtask

    task automatic test_single_icache();
        int w;
        set_req(REQ_ICACHE, 32'h1FC0_0040, 4'd15, 3'd2);
        serve(model_pick(), 2, 0, 2'b00, 1'b1, -1, w);
    endtask

    task automatic test_round_robin();
        int w;
        apply_reset();
        for (int r = 0; r < 2; r++) begin
            for (int k = 0; k < NREQ; k++) set_req(k, 32'h0010_0000 + 32'(k) * 32'h100, 4'(k + 1), 3'd2);
            repeat (NREQ) serve(model_pick(), $urandom_range(2, 0), 1, 2'b00, 1'b0, -1, w);
        end
        for (int k = 0; k < NREQ; k++) set_req(k, 32'h0020_0000 + 32'(k) * 32'h40, 4'd1, 3'd2);
        serve(model_pick(), 0, 0, 2'b00, 1'b0, -1, w);
        serve(model_pick(), 0, 0, 2'b00, 1'b0, -1, w);
        set_req(REQ_ICACHE, 32'h0030_0000, 4'd2, 3'd2);
        serve(model_pick(), 1, 0, 2'b00, 1'b0, -1, w);
        serve(model_pick(), 1, 0, 2'b00, 1'b0, -1, w);
    endtask

    task automatic test_back_to_back();
        int w;
        set_req(REQ_DCACHE, 32'h0040_0000, 4'd3, 3'd2);
        set_req(REQ_UNCACHED, 32'h0040_1000, 4'd0, 3'd2);
        serve(model_pick(), 0, 0, 2'b00, 1'b0, -1, w);
        serve(model_pick(), 0, 0, 2'b00, 1'b0, -1, w);
        n_tests++;
        if (w !== 1) begin
            n_fail++;
            $display("FAIL back_to_back_gap: got %0d idle cycles before arvalid, required 1", w);
        end
    endtask

    task automatic test_hazard();
        int w;
        write_process = 1'b1;
        write_address = 32'h0000_1010;
        set_req(REQ_DCACHE, 32'h0000_1000, 4'd3, 3'd2);
        set_req(REQ_ICACHE, 32'h0000_2000, 4'd3, 3'd2);
        serve(model_pick(), 0, 0, 2'b00, 1'b0, -1, w);
        repeat (4) begin
            @(negedge clk);
            n_tests++;
            if (bus.arvalid !== 1'b0 || dbg_state !== ST_IDLE) begin
                n_fail++;
                $display("FAIL hazard_hold: got arvalid=%b state=%0d, required 0 0", bus.arvalid, dbg_state);
            end
            tick();
        end
        write_process = 1'b0;
        serve(model_pick(), 0, 0, 2'b00, 1'b0, -1, w);
        n_tests++;
        if (w !== 1) begin
            n_fail++;
            $display("FAIL hazard_release: got arvalid after %0d cycles, required 1", w);
        end
    endtask

    task automatic test_uncached();
        int w;
        set_req(REQ_UNCACHED, 32'h1000_0004, 4'd0, 3'd0);
        serve(model_pick(), 1, 0, 2'b10, 1'b0, -1, w);
        @(negedge clk);
        n_tests++;
        if (idle !== 1'b1 || dbg_state !== ST_IDLE) begin
            n_fail++;
            $display("FAIL uncached_idle: got idle=%b state=%0d, required 1 0", idle, dbg_state);
        end
        tick();
    endtask

    task automatic test_ar_stall();
        int w;
        set_req(REQ_DCACHE, 32'h8000_1000, 4'd7, 3'd2);
        serve(model_pick(), 10, 1, 2'b00, 1'b0, -1, w);
    endtask

    task automatic test_reset_mid_burst();
        int w;
        set_req(REQ_ICACHE, 32'h1FC0_0040, 4'd15, 3'd2);
        serve(model_pick(), 0, 0, 2'b00, 1'b1, 3, w);
        tick();
        bus.rdata  = 32'h3;
        bus.rlast  = 1'b0;
        bus.rvalid = 1'b1;
        #1;
        rst_n = 1'b0;
        #1;
        n_tests++;
        if (bus.arvalid !== 1'b0 || bus.rready !== 1'b0 || resp_valid !== '0 || dbg_state !== ST_IDLE) begin
            n_fail++;
            $display("FAIL reset_mid_burst: got arv=%b rready=%b rv=%b state=%0d, required 0 0 000 0",
                     bus.arvalid, bus.rready, resp_valid, dbg_state);
        end
        bus.rvalid = 1'b0;
        repeat (2) tick();
        rst_n = 1'b1;
        model_ptr = 0;
        @(negedge clk);
        n_tests++;
        if (idle !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_idle: got idle=%b, required 1", idle);
        end
        tick();
        set_req(REQ_DCACHE, 32'h0050_0000, 4'd2, 3'd2);
        serve(model_pick(), 1, 0, 2'b00, 1'b0, -1, w);
    endtask

    task automatic test_random();
        int w;
        int p;
        int hk;
        for (int it = 0; it < 30; it++) begin
            for (int k = 0; k < NREQ; k++) begin
                if (!req_valid[k] && $urandom_range(1, 0) == 1)
                    set_req(k, $urandom(), 4'($urandom_range(7, 0)), 3'($urandom_range(2, 0)));
            end
            hk = $urandom_range(NREQ - 1, 0);
            write_process = ($urandom_range(2, 0) == 0);
            write_address = {req_addr[hk*32 + LBO +: 32 - LBO], 6'($urandom_range(63, 0))};
            if (model_pick() < 0) begin
                write_process = 1'b0;
                if (req_valid == '0) set_req(hk, $urandom(), 4'($urandom_range(7, 0)), 3'd2);
            end
            p = model_pick();
            serve(p, $urandom_range(3, 0), 2, 2'($urandom_range(3, 0)), 1'b0, -1, w);
        end
        write_process = 1'b0;
        while (req_valid != '0) serve(model_pick(), 0, 0, 2'b00, 1'b0, -1, w);
    endtask

    initial begin
        req_valid     = '0;
        req_addr      = '0;
        req_len       = '0;
        req_size      = '0;
        write_process = 1'b0;
        write_address = '0;
        bus.arready   = 1'b0;
        bus.rid       = '0;
        bus.rdata     = '0;
        bus.rresp     = 2'b00;
        bus.rlast     = 1'b0;
        bus.rvalid    = 1'b0;

        test_reset();
        test_single_icache();
        test_round_robin();
        test_back_to_back();
        test_hazard();
        test_uncached();
        test_ar_stall();
        test_reset_mid_burst();
        test_random();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
